// File: rtl/pll_supervisor_pkg.sv
// Shared types and helpers for the PLL lock supervisor: per-PLL state encoding,
// PLL index names and the timer sizing rule.
package pll_supervisor_pkg;

  typedef enum logic [1:0] {RESET, WAIT_LOCK, DEBOUNCE, LOCKED} pll_sup_state_t;

  localparam int RGMII = 0;
  localparam int SGMII = 1;
  localparam int RAM   = 2;

  // One timer serves every phase, so it must hold the longest of the three intervals.
  function automatic int timer_width(input int reset_pulse, input int lock_timeout,
                                     input int lock_debounce);
    int m;
    m = reset_pulse;
    if (lock_timeout > m) m = lock_timeout;
    if (lock_debounce > m) m = lock_debounce;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_lock_fsm.sv
// Supervision of a single PLL: lock synchronizer, reset/lock state machine with a
// shared phase timer, and saturating loss/timeout event counters.
module pll_lock_fsm
  import pll_supervisor_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int RESET_PULSE   = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int LOCK_DEBOUNCE = 1024,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lock_in,
  input  logic                 clear_counts,
  output logic                 pll_rst,
  output logic                 pll_ok,
  output logic [CNT_WIDTH-1:0] loss_count,
  output logic [CNT_WIDTH-1:0] timeout_count
);

  localparam int TW = timer_width(RESET_PULSE, LOCK_TIMEOUT, LOCK_DEBOUNCE);
  localparam logic [TW-1:0] RP_LAST = TW'(RESET_PULSE - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] DB_LAST = TW'(LOCK_DEBOUNCE - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  pll_sup_state_t         state_q, state_d;
  logic [TW-1:0]          timer_q;
  logic                   loss_evt, tmo_evt;
  logic                   rst_d, ok_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  // Stage: asynchronous LOCKED into the clk domain
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], lock_in};
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d  = state_q;
    loss_evt = 1'b0;
    tmo_evt  = 1'b0;
    case (state_q)
      RESET:     if (timer_q == RP_LAST) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        // A lock arriving on the timeout cycle still wins over the retry.
        if (lock_s) state_d = DEBOUNCE;
        else if (timer_q == TO_LAST) begin
          state_d = RESET;
          tmo_evt = 1'b1;
        end
      end
      DEBOUNCE: begin
        if (!lock_s) state_d = WAIT_LOCK;
        else if (timer_q == DB_LAST) state_d = LOCKED;
      end
      LOCKED: begin
        if (!lock_s) begin
          state_d  = RESET;
          loss_evt = 1'b1;
        end
      end
      default: state_d = RESET;
    endcase
  end

  always_comb begin
    rst_d = (state_d == RESET);
    ok_d  = (state_d == LOCKED);
  end

  // Stage: state, timer and outputs registered from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RESET;
      timer_q <= '0;
      pll_rst <= 1'b1;
      pll_ok  <= 1'b0;
    end else begin
      state_q <= state_d;
      pll_rst <= rst_d;
      pll_ok  <= ok_d;
      if (state_d != state_q)     timer_q <= '0;
      else if (state_q != LOCKED) timer_q <= timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear_counts) begin
      loss_count    <= '0;
      timeout_count <= '0;
    end else begin
      if (loss_evt) loss_count    <= sat_inc(loss_count);
      if (tmo_evt)  timeout_count <= sat_inc(timeout_count);
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Top of the PLL lock supervisor: one pll_lock_fsm per PLL, packed counter buses
// and the registered aggregate clock-good flag.
module pll_lock_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int NUM_PLLS      = 3,
  parameter int SYNC_STAGES   = 2,
  parameter int RESET_PULSE   = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int LOCK_DEBOUNCE = 1024,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PLLS-1:0]           pll_lock_in,
  input  logic                          clear_counts,
  output logic [NUM_PLLS-1:0]           pll_rst,
  output logic [NUM_PLLS-1:0]           pll_ok,
  output logic                          all_ok,
  output logic [NUM_PLLS*CNT_WIDTH-1:0] loss_count,
  output logic [NUM_PLLS*CNT_WIDTH-1:0] timeout_count
);

  for (genvar g = 0; g < NUM_PLLS; g++) begin : g_pll
    pll_lock_fsm #(
      .SYNC_STAGES  (SYNC_STAGES),
      .RESET_PULSE  (RESET_PULSE),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .LOCK_DEBOUNCE(LOCK_DEBOUNCE),
      .CNT_WIDTH    (CNT_WIDTH)
    ) u_fsm (
      .clk          (clk),
      .rst_n        (rst_n),
      .lock_in      (pll_lock_in[g]),
      .clear_counts (clear_counts),
      .pll_rst      (pll_rst[g]),
      .pll_ok       (pll_ok[g]),
      .loss_count   (loss_count[g*CNT_WIDTH +: CNT_WIDTH]),
      .timeout_count(timeout_count[g*CNT_WIDTH +: CNT_WIDTH])
    );
  end

  // Stage: aggregate flag, one cycle behind pll_ok
  always_ff @(posedge clk) begin
    if (!rst_n) all_ok <= 1'b0;
    else        all_ok <= &pll_ok;
  end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Supervises the board's clock-generation PLL/MMCMs (RGMII, SGMII and RAM PLLs) from one free-running clock.
- Synchronizes and debounces each asynchronous LOCKED signal and drives each PLL's RST input with a timed pulse.
- Retries on lock timeout and on loss of lock, and counts those events.
- Produces qualified per-PLL "clock good" flags and an aggregate flag. Downstream reset generators consume these flags to release each clock domain.

Parameters:
- NUM_PLLS, 3, number of supervised PLLs (index 0 = RGMII, 1 = SGMII, 2 = RAM).
- SYNC_STAGES, 2, synchronizer flops per lock input (minimum 2).
- RESET_PULSE, 16, clk cycles that pll_rst is held high per reset attempt.
- LOCK_TIMEOUT, 65536, clk cycles allowed in WAIT_LOCK before a retry.
- LOCK_DEBOUNCE, 1024, consecutive cycles of synchronized lock required before pll_ok is asserted.
- CNT_WIDTH, 8, width of each saturating event counter.

Ports:
- clk  in  1  free-running supervisor clock (board oscillator domain, never gated by any supervised PLL).
- rst_n  in  1  synchronous active-low reset.
- pll_lock_in  in  NUM_PLLS  raw asynchronous LOCKED outputs.
- clear_counts  in  1  single-cycle pulse; zeroes all event counters.
- pll_rst  out  NUM_PLLS  registered, active-high RST to each PLL.
- pll_ok  out  NUM_PLLS  registered; PLL locked and debounced.
- all_ok  out  1  registered AND of pll_ok.
- loss_count  out  NUM_PLLS*CNT_WIDTH  per-PLL saturating count of lock losses from LOCKED state; PLL i occupies bits [i*CNT_WIDTH +: CNT_WIDTH].
- timeout_count  out  NUM_PLLS*CNT_WIDTH  per-PLL saturating count of WAIT_LOCK timeouts; same packing.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n.
- While rst_n = 0:
  - pll_rst = all 1; pll_ok = 0; all_ok = 0; counters = 0; synchronizers = 0.
  - Every FSM is in RESET with its timer at 0.
- Synchronizer: lock_s[i] is pll_lock_in[i] after SYNC_STAGES flops. Latency is SYNC_STAGES cycles. Each PLL is independent; no cross-PLL ordering.
- Per-PLL FSM uses one timer, sized to hold the maximum of the three count parameters. The timer clears on every state change.
- RESET:
  - pll_rst = 1.
  - After RESET_PULSE cycles -> WAIT_LOCK.
  - lock_s is ignored in this state.
- WAIT_LOCK:
  - pll_rst = 0.
  - lock_s = 1 -> DEBOUNCE.
  - Timer reaches LOCK_TIMEOUT-1 with lock_s = 0 -> RESET; timeout_count[i]++.
  - If lock_s = 1 on the timeout cycle, lock wins: go to DEBOUNCE, no count.
- DEBOUNCE:
  - lock_s = 0 -> WAIT_LOCK with the timer restarted. This is not counted as a loss.
  - LOCK_DEBOUNCE consecutive high cycles -> LOCKED.
- LOCKED:
  - pll_ok = 1.
  - lock_s = 0 -> RESET; loss_count[i]++.
  - pll_ok drops on the same edge the FSM leaves LOCKED (registered from next state).
- Output timing:
  - pll_rst and pll_ok are registered from next state, so each changes on the state-change edge.
  - all_ok is registered from the pll_ok vector, one cycle later.
- Counters:
  - Saturate at 2^CNT_WIDTH-1 and never wrap.
  - clear_counts has priority over a same-cycle increment: the result is 0.
- Simultaneous events on different PLLs are fully independent.
- Reset mid-operation: asserting rst_n in any state returns that PLL to RESET on the next edge with counters cleared. A pulse already in progress restarts its full length.

Decomposition:
- Package pll_supervisor_pkg:
  - typedef enum logic [1:0] {RESET, WAIT_LOCK, DEBOUNCE, LOCKED} pll_sup_state_t.
  - Function that computes timer width from the parameters.
  - PLL index localparams RGMII=0, SGMII=1, RAM=2.
- Sub-module pll_lock_fsm:
  - Contains one synchronizer, FSM, timer and two counters.
  - Instantiated NUM_PLLS times in a generate loop.
  - Top level only packs the counter buses and computes all_ok.

Test Plan:
All scenarios use NUM_PLLS=3, SYNC_STAGES=2, RESET_PULSE=4, LOCK_TIMEOUT=32, LOCK_DEBOUNCE=8, CNT_WIDTH=4.
- Reset release with all locks tied high -> pll_rst high for 4 cycles after rst_n rises; pll_ok[2:0] = 3'b111 at cycle 4+1+2+8 (±1, checked exactly against the RTL's registering); all_ok one cycle later; all counters 0.
- Lock 1 held low -> pll_rst[1] pulses 4 cycles every 36 cycles; timeout_count[1] increments each pulse and reaches 15, then stays at 15 after 20 timeouts; PLLs 0 and 2 reach pll_ok=1 unaffected.
- Lock 0 glitches low for 3 cycles during DEBOUNCE -> no pll_ok; debounce restarts; loss_count[0]=0; pll_ok[0] rises 8 cycles after the glitch clears plus sync latency.
- Lock 2 drops for 1 cycle while LOCKED -> pll_ok[2] and all_ok fall; pll_rst[2] pulses 4 cycles; loss_count[2]=1; lock restored -> pll_ok[2] rises again.
- clear_counts asserted on the same cycle as a loss increment -> that counter reads 0 the next cycle.
- rst_n asserted mid-RESET pulse and mid-LOCKED -> pll_rst = 3'b111 and pll_ok = 0 on the next edge; the pulse restarts at full length of 4 cycles after release.
